// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter.
package pkt_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StError
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SOP  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N      = 4,
    localparam int unsigned PORT_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [PORT_W-1:0] ptr,
    output logic              any,
    output logic [PORT_W-1:0] idx
);

    logic [PORT_W-1:0] cand;

    // Scan ptr, ptr+1, ... (mod N); the first hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PORT_W'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: grants on sop, holds the grant until eop,
// and aborts the packet on an unexpected sop or a grant held too long.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned MAX_PKT_CYCLES = 256,
    localparam int unsigned PORT_W        = $clog2(N_PORTS)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [N_PORTS-1:0] cfg_port_enable,
    input  logic [N_PORTS-1:0] in_val,
    input  logic [N_PORTS-1:0] in_sop,
    input  logic [N_PORTS-1:0] in_eop,
    output logic [N_PORTS-1:0] gnt,
    output logic              out_val,
    output logic              out_sop,
    output logic              out_eop,
    output logic [PORT_W-1:0] out_port,
    output logic              error,
    output logic [PORT_W-1:0] err_port,
    output logic [1:0]        err_code
);

    localparam int unsigned TMR_W = $clog2(MAX_PKT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(MAX_PKT_CYCLES - 1);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(N_PORTS - 1);

    state_e            state_q, state_d;
    logic [PORT_W-1:0] owner_q, owner_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              first_q, first_d;
    logic [PORT_W-1:0] err_port_q, err_port_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [N_PORTS-1:0] req;
    logic               pick_any;
    logic [PORT_W-1:0]  pick_idx;
    logic [PORT_W-1:0]  owner_inc;
    logic               busy;
    logic               xfer;
    logic               beat_sop;
    logic               beat_eop;

    assign req       = in_val & in_sop & cfg_port_enable;
    assign owner_inc = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
    assign busy      = (state_q == StBusy);
    assign xfer      = busy & in_val[owner_q];
    assign beat_sop  = in_sop[owner_q];
    assign beat_eop  = in_eop[owner_q];

    rr_pick #(
        .N(N_PORTS)
    ) u_pick (
        .req(req),
        .ptr(rr_ptr_q),
        .any(pick_any),
        .idx(pick_idx)
    );

    // Output mux: the owner's stream is forwarded only while busy.
    always_comb begin
        gnt = '0;
        if (busy) begin
            gnt[owner_q] = 1'b1;
        end
        out_val  = xfer;
        out_sop  = xfer & beat_sop;
        out_eop  = xfer & beat_eop;
        out_port = owner_q;
        error    = (state_q == StError);
        err_port = err_port_q;
        err_code = err_code_q;
    end

    // Next-state logic; err_port/err_code/rr_ptr are latched on entry to
    // StError so they are already valid during the error pulse.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        first_d    = first_q;
        err_port_d = err_port_q;
        err_code_d = err_code_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StBusy;
                    owner_d = pick_idx;
                    first_d = 1'b1;
                    timer_d = '0;
                end
            end
            StBusy: begin
                if (xfer) begin
                    first_d = 1'b0;
                end
                // sop inside a packet beats eop; eop beats timeout.
                if (xfer && beat_sop && !first_q) begin
                    state_d    = StError;
                    err_code_d = ERR_SOP;
                    err_port_d = owner_q;
                    rr_ptr_d   = owner_inc;
                end else if (xfer && beat_eop) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_inc;
                end else if (timer_q == TMR_LAST) begin
                    state_d    = StError;
                    err_code_d = ERR_TMO;
                    err_port_d = owner_q;
                    rr_ptr_d   = owner_inc;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            first_q    <= 1'b0;
            err_port_q <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            first_q    <= first_d;
            err_port_q <= err_port_d;
            err_code_q <= err_code_d;
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter (4 ports, 8-cycle packet timeout).
module tb_pkt_rr_arbiter;

    logic       clk;
    logic       reset_L;
    logic [3:0] cfg_port_enable;
    logic [3:0] in_val;
    logic [3:0] in_sop;
    logic [3:0] in_eop;
    logic [3:0] gnt;
    logic       out_val;
    logic       out_sop;
    logic       out_eop;
    logic [1:0] out_port;
    logic       error;
    logic [1:0] err_port;
    logic [1:0] err_code;

    pkt_rr_arbiter #(
        .N_PORTS(4),
        .MAX_PKT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .cfg_port_enable(cfg_port_enable),
        .in_val(in_val),
        .in_sop(in_sop),
        .in_eop(in_eop),
        .gnt(gnt),
        .out_val(out_val),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .out_port(out_port),
        .error(error),
        .err_port(err_port),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model and scoreboard state.
    int         pend[4][$];
    int         len_cur[4];
    int         beat_idx[4];
    bit         active[4];
    logic [3:0] gnt_seen;
    logic [3:0] prev_gnt;
    int         exp_q[$];
    int         cyc;
    int         drop_cyc;
    int         first_rise_cyc;
    bit         check_gap;
    int         eop_cnt;
    int         err_cnt;
    int         n_cmp;
    int         n_fail;

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            pend[p].delete();
            len_cur[p]  = 0;
            beat_idx[p] = 0;
            active[p]   = 1'b0;
        end
        exp_q.delete();
        gnt_seen       = '0;
        prev_gnt       = '0;
        drop_cyc       = -1;
        first_rise_cyc = -1;
        check_gap      = 1'b0;
        in_val         = '0;
        in_sop         = '0;
        in_eop         = '0;
    endtask

    // One clock of the requester model plus the grant scoreboard monitor.
    task automatic cycle();
        int e;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (in_val[p] && gnt_seen[p]) beat_idx[p]++;
            if (active[p] && beat_idx[p] == len_cur[p]) active[p] = 1'b0;
            if (!active[p] && pend[p].size() > 0) begin
                len_cur[p]  = pend[p].pop_front();
                beat_idx[p] = 0;
                active[p]   = 1'b1;
            end
            in_val[p] = active[p];
            in_sop[p] = active[p] && beat_idx[p] == 0;
            in_eop[p] = active[p] && beat_idx[p] == len_cur[p] - 1;
        end
        #1;
        if (out_eop) eop_cnt++;
        if (error) err_cnt++;
        if (gnt != 4'b0 && gnt != prev_gnt) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant: gnt=%b, required no grant", gnt);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== 4'(1 << e) || out_port !== 2'(e)) begin
                    n_fail++;
                    $display("FAIL grant_order: gnt=%b out_port=%0d, required port %0d",
                             gnt, out_port, e);
                end
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                if (check_gap && drop_cyc >= 0) begin
                    n_cmp++;
                    if (cyc - drop_cyc != 1) begin
                        n_fail++;
                        $display("FAIL idle_gap: %0d idle cycles, required 1", cyc - drop_cyc);
                    end
                end
            end
        end
        if (gnt == 4'b0 && prev_gnt != 4'b0) drop_cyc = cyc;
        prev_gnt = gnt;
        gnt_seen = gnt;
        cyc++;
    endtask

    task automatic run_until_done(input int bound, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && gnt == 4'b0) && n < bound) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (!(exp_q.size() == 0 && gnt == 4'b0)) begin
            n_fail++;
            $display("FAIL %s_done: %0d grants pending, gnt=%b after %0d cycles, required 0",
                     name, exp_q.size(), gnt, bound);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_clear();
        cfg_port_enable = 4'b1111;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L         = 1'b0;
        cfg_port_enable = 4'b1111;
        in_val          = 4'b1111;
        in_sop          = 4'b1111;
        in_eop          = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (gnt !== 4'b0 || out_val !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b val=%b sop=%b eop=%b, required all 0",
                     gnt, out_val, out_sop, out_eop);
        end
        n_cmp++;
        if (out_port !== 2'd0 || error !== 1'b0 || err_port !== 2'd0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_status: port=%0d err=%b err_port=%0d code=%b, required 0",
                     out_port, error, err_port, err_code);
        end
        model_clear();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_two_requesters();
        int c0;
        do_reset();
        pend[0].push_back(2);
        pend[2].push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(2);
        check_gap = 1'b1;
        c0 = cyc;
        run_until_done(20, "two_req");
        n_cmp++;
        if (first_rise_cyc != c0 + 1) begin
            n_fail++;
            $display("FAIL grant_latency: first grant in cycle %0d, required %0d",
                     first_rise_cyc, c0 + 1);
        end
    endtask

    task automatic test_round_robin();
        int eop0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            pend[p].push_back(1);
            pend[p].push_back(1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) exp_q.push_back(p);
        end
        check_gap = 1'b1;
        eop0 = eop_cnt;
        run_until_done(40, "round_robin");
        n_cmp++;
        if (eop_cnt - eop0 != 8) begin
            n_fail++;
            $display("FAIL rr_eop_count: %0d eop beats, required 8", eop_cnt - eop0);
        end
    endtask

    task automatic test_sop_error();
        do_reset();
        @(negedge clk);
        in_val = 4'b0010;
        in_sop = 4'b0010;
        #1;
        n_cmp++;
        if (gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL sop_err_pre: gnt=%b, required 0000", gnt);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (gnt !== 4'b0010 || out_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL sop_err_grant: gnt=%b sop=%b, required 0010/1", gnt, out_sop);
        end
        @(negedge clk);
        in_sop = 4'b0000;
        #1;
        n_cmp++;
        if (out_val !== 1'b1 || out_sop !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_err_data: val=%b sop=%b err=%b, required 1/0/0",
                     out_val, out_sop, error);
        end
        @(negedge clk);
        in_sop = 4'b0010;
        #1;
        n_cmp++;
        if (error !== 1'b0 || out_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL sop_err_second_sop: err=%b sop=%b, required 0/1", error, out_sop);
        end
        @(negedge clk);
        in_val = '0;
        in_sop = '0;
        #1;
        n_cmp++;
        if (error !== 1'b1 || gnt !== 4'b0 || err_port !== 2'd1 || err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL sop_err_pulse: err=%b gnt=%b port=%0d code=%b, required 1/0000/1/01",
                     error, gnt, err_port, err_code);
        end
        model_clear();
        pend[1].push_back(1);
        pend[2].push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        cycle();
        n_cmp++;
        if (error !== 1'b0 || err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL sop_err_after: err=%b code=%b, required 0/01", error, err_code);
        end
        run_until_done(20, "sop_err");
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        in_val = 4'b1000;
        in_sop = 4'b1000;
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL tmo_grant: gnt=%b, required 1000", gnt);
        end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            in_val = '0;
            in_sop = '0;
            #1;
            n_cmp++;
            if (gnt !== 4'b1000 || error !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_hold_c%0d: gnt=%b err=%b, required 1000/0", k, gnt, error);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'b10 || err_port !== 2'd3 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse: err=%b code=%b port=%0d gnt=%b, required 1/10/3/0000",
                     error, err_code, err_port, gnt);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse_len: err=%b, required 0", error);
        end
        model_clear();
        pend[0].push_back(1);
        pend[3].push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(3);
        run_until_done(20, "tmo_rr");
    endtask

    task automatic test_port_enable();
        int eop0;
        int err0;
        do_reset();
        cfg_port_enable = 4'b1101;
        pend[1].push_back(1);
        pend[2].push_back(1);
        exp_q.push_back(2);
        run_until_done(20, "disabled");
        repeat (8) cycle();
        model_clear();
        cfg_port_enable = 4'b1111;
        pend[1].push_back(6);
        exp_q.push_back(1);
        for (int i = 0; i < 20 && gnt != 4'b0010; i++) cycle();
        eop0 = eop_cnt;
        err0 = err_cnt;
        cycle();
        cycle();
        cfg_port_enable = 4'b1101;
        run_until_done(20, "en_drop");
        n_cmp++;
        if (eop_cnt - eop0 != 1 || err_cnt != err0) begin
            n_fail++;
            $display("FAIL en_drop_finish: eop=%0d errors=%0d, required 1/0",
                     eop_cnt - eop0, err_cnt - err0);
        end
        pend[0].push_back(1);
        pend[1].push_back(1);
        exp_q.push_back(0);
        run_until_done(20, "en_skip");
        repeat (8) cycle();
        n_cmp++;
        if (!active[1] || beat_idx[1] != 0) begin
            n_fail++;
            $display("FAIL en_skip_port1: active=%0d beats=%0d, required 1/0",
                     active[1], beat_idx[1]);
        end
    endtask

    task automatic test_async_reset();
        int err0;
        do_reset();
        pend[1].push_back(1);
        exp_q.push_back(1);
        run_until_done(20, "ares_pre");
        pend[2].push_back(20);
        exp_q.push_back(2);
        for (int i = 0; i < 20 && gnt != 4'b0100; i++) cycle();
        cycle();
        cycle();
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0 || out_val !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b val=%b err=%b, required 0000/0/0",
                     gnt, out_val, error);
        end
        @(negedge clk);
        model_clear();
        reset_L = 1'b1;
        err0 = err_cnt;
        pend[0].push_back(1);
        pend[2].push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(2);
        run_until_done(20, "ares_post");
        n_cmp++;
        if (err_cnt != err0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL ares_no_error: errors=%0d code=%b, required 0/00",
                     err_cnt - err0, err_code);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        cyc     = 0;
        eop_cnt = 0;
        err_cnt = 0;
        reset_L = 1'b0;
        model_clear();
        cfg_port_enable = 4'b1111;
        test_reset();
        test_two_requesters();
        test_round_robin();
        test_sop_error();
        test_timeout();
        test_port_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
